// File: rtl/crc16_64b_frame_checker_pkg.sv
// -----------------------------------------------------------------------------
// crc16_pkg
// Shared definitions for the 64-bit CRC-16 framing logic:
//   CRC16_POLY / CRC16_INIT : CRC-16 (x^16+x^12+x^5+1), init 0xFFFF,
//                             no reflection, no final XOR
//   crc16_next64()          : one 64-bit word update, bytes din[7:0] first
//   chk_state_t             : frame checker state encoding
// -----------------------------------------------------------------------------
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_DRAIN
    } chk_state_t;

    // Byte-at-a-time form of the MSB-first 0x1021 CRC. The x<<12 / x<<5 / x
    // terms are the polynomial taps folded over one byte, so CRC16_POLY is
    // implicit here rather than looped over bit by bit.
    function automatic logic [15:0] crc16_next64(input logic [15:0] crc,
                                                 input logic [63:0] data);
        logic [15:0] c;
        logic [7:0]  x;
        c = crc;
        for (int unsigned k = 0; k < 8; k++) begin
            x = c[15:8] ^ data[8*k +: 8];
            x = x ^ {4'h0, x[7:4]};
            c = {c[7:0], 8'h00} ^ {x[3:0], 12'h000} ^ {3'b000, x, 5'b00000} ^ {8'h00, x};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_64b_frame_checker_step.sv
// -----------------------------------------------------------------------------
// crc16_64b_step
// Purely combinational 64-bit CRC-16 update, shareable with transmit framing.
//   i_crc  [15:0] : running CRC
//   i_data [63:0] : word, processed as bytes [7:0] first through [63:56] last
//   o_crc  [15:0] : updated CRC
// -----------------------------------------------------------------------------
module crc16_64b_step
    import crc16_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [63:0] i_data,
    output logic [15:0] o_crc
);

    assign o_crc = crc16_next64(i_crc, i_data);

endmodule

// File: rtl/crc16_64b_frame_checker.sv
// -----------------------------------------------------------------------------
// crc16_64b_frame_checker
// Receive-side CRC-16 check over 64-bit framed streams (N data words + one
// trailer word whose [15:0] holds the sender's CRC).
//   clk, rst           : clock, asynchronous active-high reset
//   din, din_valid     : stream word and qualifier (no backpressure)
//   din_last           : trailer marker, qualified by din_valid
//   frame_done         : one-cycle pulse, result outputs valid
//   crc_ok, len_err    : per-frame verdict
//   crc_calc, frame_len: computed CRC / data-word count of last frame
//   frame_cnt, err_cnt : saturating frame and bad-frame counters
// -----------------------------------------------------------------------------
module crc16_64b_frame_checker
    import crc16_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             frame_done,
    output logic             crc_ok,
    output logic             len_err,
    output logic [15:0]      crc_calc,
    output logic [15:0]      frame_len,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

    chk_state_t       r_state;
    logic [15:0]      r_crc;
    logic [15:0]      r_cnt;
    logic             r_done;
    logic             r_ok;
    logic             r_lerr;
    logic [15:0]      r_crc_calc;
    logic [15:0]      r_len;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic [15:0]      w_crc_next;
    logic             w_pass;
    logic [15:0]      w_cnt_inc;

    // r_crc sits at CRC16_INIT while idle, so one step instance serves all states
    crc16_64b_step u_step (
        .i_crc  (r_crc),
        .i_data (din),
        .o_crc  (w_crc_next)
    );

    assign w_pass    = (r_state != ST_DRAIN) && (din[15:0] == r_crc);
    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_crc       <= CRC16_INIT;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_ok        <= 1'b0;
            r_lerr      <= 1'b0;
            r_crc_calc  <= CRC16_INIT;
            r_len       <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            if (din_valid) begin
                if (din_last) begin
                    r_done     <= 1'b1;
                    r_ok       <= w_pass;
                    r_lerr     <= (r_state == ST_DRAIN);
                    r_crc_calc <= r_crc;
                    r_len      <= r_cnt;
                    if (r_frame_cnt != '1) begin
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                    end
                    if (!w_pass && (r_err_cnt != '1)) begin
                        r_err_cnt <= r_err_cnt + CNT_W'(1);
                    end
                    r_state <= ST_IDLE;
                    r_crc   <= CRC16_INIT;
                    r_cnt   <= '0;
                end else begin
                    unique case (r_state)
                        ST_IDLE: begin
                            r_crc   <= w_crc_next;
                            r_cnt   <= 16'd1;
                            r_state <= ST_DATA;
                        end
                        ST_DATA: begin
                            // A word beyond MAX_WORDS is counted but not hashed
                            if (r_cnt >= MAX_W16) begin
                                r_cnt   <= w_cnt_inc;
                                r_state <= ST_DRAIN;
                            end else begin
                                r_crc <= w_crc_next;
                                r_cnt <= r_cnt + 16'd1;
                            end
                        end
                        ST_DRAIN: begin
                            r_cnt <= w_cnt_inc;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign frame_done = r_done;
    assign crc_ok     = r_ok;
    assign len_err    = r_lerr;
    assign crc_calc   = r_crc_calc;
    assign frame_len  = r_len;
    assign frame_cnt  = r_frame_cnt;
    assign err_cnt    = r_err_cnt;

endmodule

// File: doc/crc16_64b_frame_checker.md
# crc16_64b_frame_checker

Receive-side counterpart of `crc16_64b_parallel`. It consumes a stream of 64-bit words that make up a frame: N data words, then one trailer word that carries the sender's CRC-16. It recomputes the CRC over the data words, compares it with the trailer, and reports a registered pass/fail per frame. It also keeps saturating frame and error counters for the slow-control register map.

## Interface
Parameters:
- `MAX_WORDS`, default 256: maximum data words per frame, excluding the trailer. Range 1..65535.
- `CNT_W`, default 16: width of `frame_cnt` and `err_cnt`.

Ports:
- `clk`, in, 1: single clock domain.
- `rst`, in, 1: reset, asynchronous and active-high.
- `din`, in, 64: stream word.
- `din_valid`, in, 1: `din` is valid this cycle. There is no backpressure; every valid word is accepted.
- `din_last`, in, 1: qualified by `din_valid`. Marks the trailer word; the CRC is in `din[15:0]`, and `din[63:16]` is ignored.
- `frame_done`, out, 1: one-cycle pulse when a frame result is available.
- `crc_ok`, out, 1: valid with `frame_done`. The computed CRC matched and the length was legal.
- `len_err`, out, 1: valid with `frame_done`. The frame had more than `MAX_WORDS` data words.
- `crc_calc`, out, 16: computed CRC of the last completed frame. Held until the next `frame_done`.
- `frame_len`, out, 16: data-word count of the last completed frame, saturating at 0xFFFF.
- `frame_cnt`, out, `CNT_W`: number of completed frames, saturating.
- `err_cnt`, out, `CNT_W`: number of frames with `crc_ok`=0, saturating.

## Operation
CRC definition. It must be bit-identical to `crc16_64b_parallel` for the same words.
- Polynomial x^16+x^12+x^5+1 (0x1021), initial value 0xFFFF.
- No reflection, no final XOR.
- Each word is processed as bytes `din[7:0]` first through `din[63:56]` last. This is equivalent to the 8-bit `crc` module fed in that byte order.

State machine (`IDLE`, `DATA`, `DRAIN`):
- `IDLE`: running CRC = 0xFFFF, word count = 0.
  - Valid non-last word: update CRC, count = 1, go to `DATA`. If `MAX_WORDS` is 1, the next data word sends the machine to `DRAIN`.
  - Valid last word: zero-length frame. Compare `din[15:0]` with 0xFFFF, complete the frame, stay in `IDLE`.
- `DATA`:
  - Valid non-last word: update CRC, increment count.
  - A data word that would make count exceed `MAX_WORDS`: go to `DRAIN` and flag a length error.
  - Valid last word: compare `din[15:0]` with the running CRC, complete the frame, return to `IDLE`.
- `DRAIN`:
  - Non-last words are discarded; count keeps incrementing (saturating).
  - Last word: complete the frame with `len_err`=1 and `crc_ok`=0, return to `IDLE`.

Completing a frame:
- Registers `crc_ok`, `len_err`, `crc_calc` and `frame_len`, and pulses `frame_done`.
- Increments `frame_cnt`, and increments `err_cnt` when `crc_ok`=0.
- Both counters saturate at all-ones and never wrap.

Input rules:
- `din_valid`=0 cycles (gaps) inside a frame are allowed and change no state.
- `din_last` without `din_valid` is ignored.

## Timing
- Reset values: `frame_done`=0, `crc_ok`=0, `len_err`=0, `crc_calc`=0xFFFF, `frame_len`=0, `frame_cnt`=0, `err_cnt`=0, state `IDLE`.
- Latency: a trailer accepted on edge k produces `frame_done` high for exactly cycle k+1. All result outputs update on that same edge.
- Back-to-back frames are supported: a new first word can arrive the cycle after a trailer. `frame_done` can then be high on consecutive cycles for consecutive one-word (trailer-only) frames.
- Throughput: one word per clock. The 64-bit CRC update is a single combinational step followed by a register.
- Reset mid-frame: the partial frame is discarded, no `frame_done` is generated, and the counters are cleared.
- Counter saturation and a `frame_done` in the same cycle: the counter holds at all-ones and the result outputs still update.

## Structure
- Package `crc16_pkg`:
  - `CRC16_POLY` = 16'h1021 and `CRC16_INIT` = 16'hFFFF.
  - Function `crc16_next64(crc, data)` implementing the byte-ordered 64-bit update.
  - The state enum type.
- One sub-module, `crc16_64b_step`: purely combinational wrapper around `crc16_next64`. It can be shared with future transmit-side framing logic.

## Test plan
- Reset, then one trailer word with `din[15:0]`=0xFFFF: `frame_done` on the next cycle, `crc_ok`=1, `frame_len`=0, `frame_cnt`=1.
- Data words 0x123456789abcdef0 and 0x1234000056780000, then a trailer carrying the `crc16_64b_parallel` result for the same two words:
  - `crc_ok`=1 and `crc_calc` equal to that result.
  - `crc_calc` must also equal the 8-bit `crc` module fed bytes f0,de,bc,9a,78,56,34,12,00,00,78,56,00,00,34,12.
- The same frame with bit 0 of the trailer flipped: `crc_ok`=0, `err_cnt` increments by 1. Repeat with idle gaps between words: the result must be identical.
- With `MAX_WORDS`=4, send 6 data words then a trailer: `len_err`=1, `crc_ok`=0, `frame_len`=6. The next legal frame passes.
- Assert `rst` after 2 words of a frame, then send a complete legal frame: no spurious `frame_done`, the new frame passes, `frame_cnt`=1.
- With `CNT_W`=2, send 5 bad frames: `err_cnt` and `frame_cnt` stop at 3.
